sfp_norm_row: RTL and testbench
===============================

SFP_NORM_ROW -- requirements
Module: sfp_norm_row

Interface
REQ-001 Parameter COL, default 8, number of columns per row.
REQ-002 Parameter BW_PSUM, default 20, signed psum width per column, also the output lane width.
REQ-003 Parameter FRAC, default 8, fractional bits of the normalized output.
REQ-004 Parameter DEPTH, default 16, entries per sum FIFO, power of two.
REQ-005 Derived SUM_W = BW_PSUM + clog2(COL) + 1, the width of the row sum.
REQ-006 Port clk, in, 1 bit: clock, all logic on its rising edge.
REQ-007 Port reset, in, 1 bit: reset, synchronous, active-high.
REQ-008 Port mode, in, 1 bit: 0 = absolute-value normalize, 1 = ReLU normalize (negative lanes treated as 0).
REQ-009 Port acc, in, 1 bit: accumulate strobe for the row presented on sfp_in.
REQ-010 Port sfp_in, in, COL*BW_PSUM: two's-complement lanes, lane 0 at the LSBs.
REQ-011 Port sum_in, in, SUM_W: partial row sum from the partner core.
REQ-012 Port sum_out, out, SUM_W: registered local row sum, exported to the partner core.
REQ-013 Port div_valid, in, 1 bit: divide request for the row presented on sfp_in.
REQ-014 Port div_ready, out, 1 bit: block can accept a divide request.
REQ-015 Port out_valid, out, 1 bit: single-cycle pulse marking sfp_out and div_zero valid.
REQ-016 Port sfp_out, out, COL*BW_PSUM: unsigned normalized lanes.
REQ-017 Port div_zero, out, 1 bit: divisor was zero for the current result.
REQ-018 Ports fifo_full and fifo_empty, out, 1 bit each: status of the local FIFO.
REQ-019 Port ovf, out, 1 bit: sticky flag, an acc write was dropped.

Function
REQ-020 Each lane magnitude shall be |x| in mode 0, and x if x >= 0 else 0 in mode 1; the magnitude of the most negative value shall be 2^(BW_PSUM-1).
REQ-021 On a cycle with acc=1, the magnitude sum shall be written to the local FIFO, sum_in shall be written to the ext FIFO, and sum_out shall update at the next edge.
REQ-022 If acc=1 while fifo_full=1 and no pop occurs that cycle, both writes shall be dropped and ovf shall set.
REQ-023 div_ready shall be 1 only when the state is IDLE and fifo_empty=0.
REQ-024 A request is accepted on a cycle with div_valid=1 and div_ready=1; on acceptance the block shall:
  - latch the lane magnitudes and mode;
  - pop both FIFOs;
  - set divisor = local + ext, SUM_W+1 bits.
REQ-025 The FSM shall step IDLE -> DIV -> DONE -> IDLE.
REQ-026 DIV shall last exactly BW_PSUM+FRAC cycles: restoring radix-2 division, all lanes in parallel.
REQ-027 Lane result shall be floor(mag*2^FRAC / divisor), saturated to 2^BW_PSUM-1.
REQ-028 Latency: accept at cycle t gives out_valid=1 during cycle t+BW_PSUM+FRAC+1, for one cycle only; sfp_out shall hold until the next result.
REQ-029 If divisor=0, all lanes shall be 0 and div_zero=1 with out_valid.
REQ-030 Simultaneous push and pop shall both take effect, including when full; FIFO order is strict FIFO.
REQ-031 acc and the FIFO writes shall operate in every FSM state.

Reset
REQ-032 On reset: state IDLE, FIFOs empty, and sum_out, sfp_out, out_valid, div_zero, ovf all 0.
REQ-033 Reset mid-division shall abort the operation with no out_valid pulse.

Structure
REQ-034 Package sfp_pkg shall hold the FSM state enum, the mode encoding and the SUM_W derivation.
REQ-035 The sum FIFOs shall be sub-module sfp_sum_fifo (parameters width, DEPTH), instantiated twice.

Verification (COL=8, BW_PSUM=20, FRAC=8)
REQ-036 Mode 0 case:
  - stimulus: lanes {-4,4,8,0,0,0,0,16}, sum_in=0, acc, then div;
  - response: sum_out=32; sfp_out={32,32,64,0,0,0,0,128} at accept+29.
REQ-037 Mode 1 case:
  - stimulus: same lanes, mode=1;
  - response: sum_out=28; sfp_out={0,36,73,0,0,0,0,146}.
REQ-038 Partner-sum case:
  - stimulus: REQ-036 with sum_in=32;
  - response: divisor 64; sfp_out={16,16,32,0,0,0,0,64}.
REQ-039 Zero case:
  - stimulus: all lanes 0, sum_in=0, acc, div;
  - response: div_zero=1, all lanes 0.
REQ-040 FIFO boundary case:
  - stimulus: 17 accs with distinct sums;
  - response: fifo_full=1 and ovf=1 after the 17th; 16 divs drain in order; then fifo_empty=1 and div_ready=0.
REQ-041 Reset case:
  - stimulus: reset 5 cycles after accept;
  - response: no out_valid, state IDLE, fifo_empty=1, all outputs 0.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared types and width helpers for the row-normalize block.
package sfp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ABS  = 1'b0,
    MODE_RELU = 1'b1
  } mode_e;

  // Row sum width: one psum lane widened for COL additions plus a guard bit.
  function automatic int unsigned sum_w(input int unsigned col, input int unsigned bw_psum);
    return bw_psum + $clog2(col) + 1;
  endfunction

endpackage

// File: rtl/sfp_norm_row_if.sv
// Row data, partner-sum exchange, divide handshake and status of sfp_norm_row.
interface sfp_norm_row_if #(
  parameter int unsigned COL     = 8,
  parameter int unsigned BW_PSUM = 20
) ();
  import sfp_pkg::*;

  localparam int unsigned SUM_W = sum_w(COL, BW_PSUM);

  logic                     mode;
  logic                     acc;
  logic [COL*BW_PSUM-1:0]   sfp_in;
  logic [SUM_W-1:0]         sum_in;
  logic [SUM_W-1:0]         sum_out;
  logic                     div_valid;
  logic                     div_ready;
  logic                     out_valid;
  logic [COL*BW_PSUM-1:0]   sfp_out;
  logic                     div_zero;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     ovf;

  modport master (
    output mode, acc, sfp_in, sum_in, div_valid,
    input  sum_out, div_ready, out_valid, sfp_out, div_zero, fifo_full, fifo_empty, ovf
  );

  modport slave (
    input  mode, acc, sfp_in, sum_in, div_valid,
    output sum_out, div_ready, out_valid, sfp_out, div_zero, fifo_full, fifo_empty, ovf
  );

endinterface

// File: rtl/sfp_sum_fifo.sv
// Show-ahead FIFO for row sums; a pop frees a slot for a push in the same cycle.
module sfp_sum_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/sfp_norm_row.sv
// Row normalizer: lane magnitudes divided by the combined local+partner row sum,
// fixed-point result with FRAC fraction bits, one restoring divider per lane.
module sfp_norm_row
  import sfp_pkg::*;
#(
  parameter int unsigned COL     = 8,
  parameter int unsigned BW_PSUM = 20,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned DEPTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  sfp_norm_row_if.slave bus
);

  localparam int unsigned SUM_W = sum_w(COL, BW_PSUM);
  localparam int unsigned DW    = SUM_W + 1;
  localparam int unsigned QW    = BW_PSUM + FRAC;
  localparam int unsigned CW    = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [DW-1:0]          div_q;
  logic                   zero_q;
  logic [DW-1:0]          rem_q [COL];
  logic [QW-1:0]          qd_q  [COL];
  logic [COL*BW_PSUM-1:0] sfp_out_q;
  logic                   out_valid_q, div_zero_q, ovf_q;
  logic [SUM_W-1:0]       sum_out_q;

  logic [BW_PSUM-1:0]     mag [COL];
  logic [SUM_W-1:0]       msum;
  logic [SUM_W-1:0]       loc_head, ext_head;
  logic                   loc_full, loc_empty, ext_full, ext_empty;
  logic                   accept, push;
  logic [DW-1:0]          div_sum;

  logic [DW:0]            rem_sh [COL];
  logic                   ge     [COL];
  logic [DW-1:0]          rem_d  [COL];
  logic [QW-1:0]          qd_d   [COL];
  logic [BW_PSUM-1:0]     sat    [COL];

  // Negating the most negative lane yields 2^(BW_PSUM-1) as an unsigned pattern.
  always_comb begin
    msum = '0;
    for (int unsigned i = 0; i < COL; i++) begin
      if (bus.sfp_in[i*BW_PSUM + BW_PSUM-1])
        mag[i] = (bus.mode == MODE_RELU) ? '0 : BW_PSUM'(-bus.sfp_in[i*BW_PSUM +: BW_PSUM]);
      else
        mag[i] = bus.sfp_in[i*BW_PSUM +: BW_PSUM];
      msum = msum + SUM_W'(mag[i]);
    end
  end

  assign bus.fifo_full  = loc_full | ext_full;
  assign bus.fifo_empty = loc_empty | ext_empty;
  assign bus.div_ready  = (state_q == ST_IDLE) && !bus.fifo_empty;
  assign accept         = bus.div_valid && bus.div_ready;
  assign push           = bus.acc && (!bus.fifo_full || accept);
  assign div_sum        = DW'(loc_head) + DW'(ext_head);

  sfp_sum_fifo #(.WIDTH(SUM_W), .DEPTH(DEPTH)) u_loc_fifo (
    .clk(clk), .reset(reset), .push_i(push), .din_i(msum), .pop_i(accept),
    .dout_o(loc_head), .full_o(loc_full), .empty_o(loc_empty)
  );

  sfp_sum_fifo #(.WIDTH(SUM_W), .DEPTH(DEPTH)) u_ext_fifo (
    .clk(clk), .reset(reset), .push_i(push), .din_i(bus.sum_in), .pop_i(accept),
    .dout_o(ext_head), .full_o(ext_full), .empty_o(ext_empty)
  );

  // One restoring step per lane: dividend bits shift out of qd while quotient bits shift in.
  always_comb begin
    for (int unsigned i = 0; i < COL; i++) begin
      rem_sh[i] = {rem_q[i], qd_q[i][QW-1]};
      ge[i]     = rem_sh[i] >= {1'b0, div_q};
      rem_d[i]  = ge[i] ? DW'(rem_sh[i] - {1'b0, div_q}) : rem_sh[i][DW-1:0];
      qd_d[i]   = {qd_q[i][QW-2:0], ge[i]};
      sat[i]    = (|qd_d[i][QW-1:BW_PSUM]) ? '1 : qd_d[i][BW_PSUM-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      sfp_out_q   <= '0;
      sum_out_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.acc) sum_out_q <= msum;
      if (bus.acc && bus.fifo_full && !accept) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_DIV;
            cnt_q   <= '0;
          end
        end
        ST_DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            div_zero_q  <= zero_q;
            for (int unsigned i = 0; i < COL; i++)
              sfp_out_q[i*BW_PSUM +: BW_PSUM] <= zero_q ? '0 : sat[i];
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      div_q  <= div_sum;
      zero_q <= (div_sum == '0);
      for (int unsigned i = 0; i < COL; i++) begin
        rem_q[i] <= '0;
        qd_q[i]  <= {mag[i], {FRAC{1'b0}}};
      end
    end else if (state_q == ST_DIV) begin
      for (int unsigned i = 0; i < COL; i++) begin
        rem_q[i] <= rem_d[i];
        qd_q[i]  <= qd_d[i];
      end
    end
  end

  assign bus.sum_out   = sum_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sfp_out   = sfp_out_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sfp_norm_row.sv
// Bench for sfp_norm_row: directed rows, a queue-based model checked every cycle,
// and literal expectations for the worked cases.
module tb_sfp_norm_row;

  localparam int COL   = 8;
  localparam int BW    = 20;
  localparam int FRAC  = 8;
  localparam int DEPTH = 16;
  localparam int SUM_W = BW + $clog2(COL) + 1;
  localparam int VW    = COL * BW;
  localparam longint SAT = (longint'(1) << BW) - 1;

  typedef logic [VW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sfp_norm_row_if #(.COL(COL), .BW_PSUM(BW)) bus ();

  sfp_norm_row #(.COL(COL), .BW_PSUM(BW), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t pack8(input int v[COL]);
    vec_t r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v[i]);
    return r;
  endfunction

  function automatic longint lane_of(input vec_t v, input int i);
    logic [BW-1:0] x;
    x = v[i*BW +: BW];
    return longint'(x);
  endfunction

  function automatic longint mag_of(input vec_t v, input int i, input bit m);
    logic [BW-1:0] x;
    longint s;
    x = v[i*BW +: BW];
    s = longint'($signed(x));
    if (s >= 0) return s;
    return m ? 0 : -s;
  endfunction

  function automatic longint msum_of(input vec_t v, input bit m);
    longint s = 0;
    for (int i = 0; i < COL; i++) s += mag_of(v, i, m);
    return s;
  endfunction

  function automatic vec_t expect_out(input vec_t v, input bit m, input longint d);
    vec_t r = '0;
    longint q;
    for (int i = 0; i < COL; i++) begin
      q = (d == 0) ? 0 : (mag_of(v, i, m) << FRAC) / d;
      if (q > SAT) q = SAT;
      r[i*BW +: BW] = BW'(q);
    end
    return r;
  endfunction

  // Reference model, advanced on each rising edge from the inputs the bench drives.
  longint loc_q[$];
  longint ext_q[$];
  int     busy = 0;
  longint exp_sum_out = 0;
  bit     exp_ovf = 0, exp_dz = 0, pend_dz = 0;
  vec_t   exp_sfp = '0, pend_sfp = '0;
  bit     started = 0;

  always @(posedge clk) begin
    if (reset) begin
      loc_q.delete();
      ext_q.delete();
      busy = 0;
      exp_sum_out = 0;
      exp_ovf = 0;
      exp_dz = 0;
      exp_sfp = '0;
    end else begin
      bit ready, pop;
      longint l, e;
      ready = (busy == 0) && (loc_q.size() > 0);
      pop   = bus.div_valid && ready;
      if (pop) begin
        l = loc_q.pop_front();
        e = ext_q.pop_front();
        pend_sfp = expect_out(bus.sfp_in, bus.mode, l + e);
        pend_dz  = (l + e == 0);
      end
      if (bus.acc) begin
        exp_sum_out = msum_of(bus.sfp_in, bus.mode);
        if (loc_q.size() < DEPTH) begin
          loc_q.push_back(exp_sum_out);
          ext_q.push_back(longint'(bus.sum_in));
        end else begin
          exp_ovf = 1;
        end
      end
      if (pop) busy = BW + FRAC + 1;
      else if (busy > 0) busy--;
      if (busy == 1) begin
        exp_sfp = pend_sfp;
        exp_dz  = pend_dz;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("out_valid", longint'(bus.out_valid), longint'(busy == 1));
      chkv("sfp_out", bus.sfp_out, exp_sfp);
      chk("div_zero", longint'(bus.div_zero), longint'(exp_dz));
      chk("sum_out", longint'(bus.sum_out), exp_sum_out);
      chk("ovf", longint'(bus.ovf), longint'(exp_ovf));
      chk("fifo_full", longint'(bus.fifo_full), longint'(loc_q.size() == DEPTH));
      chk("fifo_empty", longint'(bus.fifo_empty), longint'(loc_q.size() == 0));
      chk("div_ready", longint'(bus.div_ready), longint'(busy == 0 && loc_q.size() > 0));
    end
  end

  task automatic do_acc(input vec_t v, input bit m, input longint s);
    @(negedge clk);
    bus.sfp_in = v;
    bus.mode   = m;
    bus.sum_in = SUM_W'(s);
    bus.acc    = 1'b1;
    @(negedge clk);
    bus.acc = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.div_ready) chk("div_ready_timeout", longint'(bus.div_ready), 1);
  endtask

  // Returns the number of falling edges from accept to the out_valid pulse.
  task automatic do_div(input vec_t v, input bit m, input bit with_acc, input longint s,
                        output int lat);
    wait_ready();
    bus.sfp_in    = v;
    bus.mode      = m;
    bus.sum_in    = SUM_W'(s);
    bus.acc       = with_acc;
    bus.div_valid = 1'b1;
    @(negedge clk);
    bus.div_valid = 1'b0;
    bus.acc       = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_lanes(input string tag, input int e[COL]);
    for (int i = 0; i < COL; i++)
      chk($sformatf("%s_lane%0d", tag, i), lane_of(bus.sfp_out, i), longint'(e[i]));
  endtask

  vec_t row_a, row_z, row_d;
  int   lat;
  int   pulses;

  initial begin
    bus.mode = 1'b0; bus.acc = 1'b0; bus.sfp_in = '0; bus.sum_in = '0; bus.div_valid = 1'b0;
    row_a = pack8('{-4, 4, 8, 0, 0, 0, 0, 16});
    row_z = '0;
    row_d = pack8('{5000, -524288, 0, 0, 0, 0, 0, 0});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_fifo_empty", longint'(bus.fifo_empty), 1);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_sum_out", longint'(bus.sum_out), 0);
    chk("reset_div_ready", longint'(bus.div_ready), 0);

    // Absolute-value normalize, divisor 32
    do_acc(row_a, 1'b0, 0);
    chk("m0_sum_out", longint'(bus.sum_out), 32);
    do_div(row_a, 1'b0, 1'b0, 0, lat);
    chk("m0_latency", lat, 29);
    check_lanes("m0", '{32, 32, 64, 0, 0, 0, 0, 128});

    // ReLU normalize, divisor 28
    do_acc(row_a, 1'b1, 0);
    chk("m1_sum_out", longint'(bus.sum_out), 28);
    do_div(row_a, 1'b1, 1'b0, 0, lat);
    chk("m1_latency", lat, 29);
    check_lanes("m1", '{0, 36, 73, 0, 0, 0, 0, 146});

    // Partner sum doubles the divisor to 64
    do_acc(row_a, 1'b0, 32);
    chk("ps_sum_out", longint'(bus.sum_out), 32);
    do_div(row_a, 1'b0, 1'b0, 0, lat);
    check_lanes("ps", '{16, 16, 32, 0, 0, 0, 0, 64});

    // Zero divisor
    do_acc(row_z, 1'b0, 0);
    do_div(row_z, 1'b0, 1'b0, 0, lat);
    chk("zero_div_zero", longint'(bus.div_zero), 1);
    chk("zero_out_valid", longint'(bus.out_valid), 1);
    check_lanes("zero", '{0, 0, 0, 0, 0, 0, 0, 0});

    // Fill to the boundary, then overflow on the 17th write
    for (int k = 0; k < DEPTH + 1; k++) begin
      do_acc(pack8('{k + 1, 0, 0, 0, 0, 0, 0, 0}), 1'b0, 3 * k);
      if (k == DEPTH - 1) begin
        chk("fill16_full", longint'(bus.fifo_full), 1);
        chk("fill16_ovf", longint'(bus.ovf), 0);
      end
    end
    chk("fill17_full", longint'(bus.fifo_full), 1);
    chk("fill17_ovf", longint'(bus.ovf), 1);

    // First drain also pushes while full; divisor 1 saturates both non-zero lanes
    do_div(row_d, 1'b0, 1'b1, 7, lat);
    check_lanes("drain0", '{1048575, 1048575, 0, 0, 0, 0, 0, 0});
    do_div(row_d, 1'b0, 1'b0, 0, lat);
    chk("drain1_lane0", lane_of(bus.sfp_out, 0), 256000);
    for (int k = 2; k < DEPTH + 1; k++) do_div(row_d, 1'b0, 1'b0, 0, lat);
    @(negedge clk);
    chk("drained_fifo_empty", longint'(bus.fifo_empty), 1);
    chk("drained_div_ready", longint'(bus.div_ready), 0);
    chk("drained_ovf_sticky", longint'(bus.ovf), 1);

    // Reset during division aborts without a result pulse
    do_acc(row_a, 1'b0, 0);
    wait_ready();
    bus.sfp_in = row_a;
    bus.div_valid = 1'b1;
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_fifo_empty", longint'(bus.fifo_empty), 1);
    chk("abort_div_ready", longint'(bus.div_ready), 0);
    chkv("abort_sfp_out", bus.sfp_out, '0);
    chk("abort_sum_out", longint'(bus.sum_out), 0);
    chk("abort_ovf", longint'(bus.ovf), 0);
    chk("abort_div_zero", longint'(bus.div_zero), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
